// File: rtl/apb_master_fsm.sv
// apb_master_fsm: APB3 master with a one-entry request buffer and an access timeout.
module apb_master_fsm #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NSLV    = 3,
    parameter int TIMEOUT = 16
) (
    input  logic              Hclk,
    input  logic              Hresetn,
    input  logic              valid,
    input  logic [ADDR_W-1:0] Haddr,
    input  logic [DATA_W-1:0] Hwdata,
    input  logic              Hwrite,
    input  logic [NSLV-1:0]   tempselx,
    output logic              Hreadyout,
    output logic [ADDR_W-1:0] Paddr,
    output logic [DATA_W-1:0] Pwdata,
    output logic              Pwrite,
    output logic [NSLV-1:0]   Pselx,
    output logic              Penable,
    input  logic [DATA_W-1:0] Prdata,
    input  logic              Pready,
    input  logic              Pslverr,
    output logic              Hdone,
    output logic [DATA_W-1:0] Hrdata,
    output logic              Hresp
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic              buf_v_q;
    logic              buf_wr_q;
    logic [ADDR_W-1:0] buf_addr_q;
    logic [DATA_W-1:0] buf_data_q;
    logic [NSLV-1:0]   buf_sel_q;
    logic              accept;
    logic              timeout_hit;
    logic              done;
    logic              start;
    logic [DATA_W-1:0] req_data;
    logic [ADDR_W-1:0] nxt_addr;
    logic [DATA_W-1:0] nxt_data;
    logic              nxt_wr;
    logic [NSLV-1:0]   nxt_sel;

    assign accept      = valid && Hreadyout;
    assign timeout_hit = (TIMEOUT > 0) && !Pready && (int'(cnt_q) + 1 == TIMEOUT);
    assign done        = (state_q == ACCESS) && (Pready || timeout_hit);
    assign start       = (state_q == IDLE && accept) || (done && (buf_v_q || accept));
    assign req_data    = Hwrite ? Hwdata : '0;
    // A buffered request always wins; otherwise the live request goes straight to the bus.
    assign nxt_addr    = buf_v_q ? buf_addr_q : Haddr;
    assign nxt_data    = buf_v_q ? buf_data_q : req_data;
    assign nxt_wr      = buf_v_q ? buf_wr_q : Hwrite;
    assign nxt_sel     = buf_v_q ? buf_sel_q : tempselx;

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            buf_v_q    <= 1'b0;
            buf_wr_q   <= 1'b0;
            buf_addr_q <= '0;
            buf_data_q <= '0;
            buf_sel_q  <= '0;
            Hreadyout  <= 1'b1;
            Paddr      <= '0;
            Pwdata     <= '0;
            Pwrite     <= 1'b0;
            Pselx      <= '0;
            Penable    <= 1'b0;
            Hdone      <= 1'b0;
            Hrdata     <= '0;
            Hresp      <= 1'b0;
        end else begin
            Hdone <= 1'b0;
            if (accept && state_q != IDLE && !done) begin
                buf_v_q    <= 1'b1;
                buf_addr_q <= Haddr;
                buf_data_q <= req_data;
                buf_wr_q   <= Hwrite;
                buf_sel_q  <= tempselx;
                Hreadyout  <= 1'b0;
            end
            if (start) begin
                state_q   <= SETUP;
                Paddr     <= nxt_addr;
                Pwdata    <= nxt_data;
                Pwrite    <= nxt_wr;
                Pselx     <= nxt_sel;
                Penable   <= 1'b0;
                cnt_q     <= '0;
                buf_v_q   <= 1'b0;
                Hreadyout <= 1'b1;
            end else if (state_q == SETUP) begin
                state_q <= ACCESS;
                Penable <= 1'b1;
            end else if (done) begin
                state_q <= IDLE;
                Pselx   <= '0;
                Penable <= 1'b0;
                cnt_q   <= '0;
            end else if (state_q == ACCESS && !Pready) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (done) begin
                Hdone  <= 1'b1;
                Hresp  <= Pready ? Pslverr : 1'b1;
                Hrdata <= (Pready && !Pslverr && !Pwrite) ? Prdata : '0;
            end
        end
    end
endmodule

// File: tb/tb_apb_master_fsm.sv
// tb_apb_master_fsm: random requests and slave responses checked against a transaction-queue model.
module tb_apb_master_fsm;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 3;
    localparam int TO = 16;

    logic          Hclk = 1'b0;
    logic          Hresetn = 1'b0;
    logic          valid = 1'b0;
    logic [AW-1:0] Haddr = '0;
    logic [DW-1:0] Hwdata = '0;
    logic          Hwrite = 1'b0;
    logic [NS-1:0] tempselx = '0;
    logic [DW-1:0] Prdata = '0;
    logic          Pready = 1'b0;
    logic          Pslverr = 1'b0;
    logic          Hreadyout;
    logic [AW-1:0] Paddr;
    logic [DW-1:0] Pwdata;
    logic          Pwrite;
    logic [NS-1:0] Pselx;
    logic          Penable;
    logic          Hdone;
    logic [DW-1:0] Hrdata;
    logic          Hresp;

    always #5 Hclk = ~Hclk;

    apb_master_fsm #(.ADDR_W(AW), .DATA_W(DW), .NSLV(NS), .TIMEOUT(TO)) dut (
        .Hclk(Hclk), .Hresetn(Hresetn), .valid(valid), .Haddr(Haddr), .Hwdata(Hwdata),
        .Hwrite(Hwrite), .tempselx(tempselx), .Hreadyout(Hreadyout), .Paddr(Paddr),
        .Pwdata(Pwdata), .Pwrite(Pwrite), .Pselx(Pselx), .Penable(Penable), .Prdata(Prdata),
        .Pready(Pready), .Pslverr(Pslverr), .Hdone(Hdone), .Hrdata(Hrdata), .Hresp(Hresp)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          wr;
        logic [NS-1:0] sel;
    } req_t;

    req_t          q[$];
    req_t          cur;
    int            phase;
    int            waits;
    int            n_done;
    logic          e_done;
    logic          e_resp;
    logic [DW-1:0] e_rdata;
    int            n_chk = 0;
    int            n_err = 0;
    int            vp[5] = '{50, 100, 30, 50, 100};
    int            pp[5] = '{100, 70, 20, 0, 60};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        cur     = '0;
        phase   = 0;
        waits   = 0;
        e_done  = 1'b0;
        e_resp  = 1'b0;
        e_rdata = '0;
    endtask

    task automatic check_outputs();
        check("hreadyout", 64'(Hreadyout), 64'(q.size() == 0));
        check("hdone", 64'(Hdone), 64'(e_done));
        check("hresp", 64'(Hresp), 64'(e_resp));
        check("hrdata", 64'(Hrdata), 64'(e_rdata));
        check("pselx", 64'(Pselx), 64'(phase == 0 ? NS'(0) : cur.sel));
        check("penable", 64'(Penable), 64'(phase == 2));
        check("paddr", 64'(Paddr), 64'(cur.addr));
        check("pwrite", 64'(Pwrite), 64'(cur.wr));
        check("pwdata", 64'(Pwdata), 64'(cur.wdata));
    endtask

    task automatic drive(input int mode);
        valid    = $urandom_range(0, 99) < vp[mode];
        Haddr    = $urandom;
        Hwdata   = $urandom;
        Hwrite   = 1'($urandom_range(0, 1));
        tempselx = NS'(1) << $urandom_range(0, NS - 1);
        Pready   = $urandom_range(0, 99) < pp[mode];
        Pslverr  = $urandom_range(0, 9) == 0;
        Prdata   = $urandom;
    endtask

    // What the DUT should do on the coming rising edge, in transaction terms.
    task automatic model_step();
        req_t r;
        logic acc;
        r.addr  = Haddr;
        r.wdata = Hwrite ? Hwdata : '0;
        r.wr    = Hwrite;
        r.sel   = tempselx;
        acc     = valid && (q.size() == 0);
        e_done  = 1'b0;
        if (phase == 0) begin
            if (acc) begin
                cur   = r;
                phase = 1;
            end
        end else if (phase == 1) begin
            phase = 2;
            if (acc) q.push_back(r);
        end else if (Pready || waits + 1 == TO) begin
            e_done  = 1'b1;
            n_done++;
            e_resp  = Pready ? Pslverr : 1'b1;
            e_rdata = (Pready && !Pslverr && !cur.wr) ? Prdata : '0;
            waits   = 0;
            if (q.size() > 0) begin
                cur   = q.pop_front();
                phase = 1;
            end else if (acc) begin
                cur   = r;
                phase = 1;
            end else begin
                phase = 0;
            end
        end else begin
            waits++;
            if (acc) q.push_back(r);
        end
    endtask

    task automatic cycle(input int mode);
        drive(mode);
        model_step();
        @(negedge Hclk);
        check_outputs();
    endtask

    initial begin
        int guard;
        int done0;
        model_reset();
        n_done = 0;
        repeat (2) @(negedge Hclk);
        check_outputs();
        Hresetn = 1'b1;
        for (int m = 0; m < 4; m++) repeat (400) cycle(m);
        done0 = n_done;
        guard = 0;
        while (!(phase == 2 && q.size() == 1 && n_done > done0) && guard < 300) begin
            cycle(4);
            guard++;
        end
        check("reach_queued_access", 64'(guard < 300), 64'(1));
        valid  = 1'b0;
        Pready = 1'b0;
        #1 Hresetn = 1'b0;
        #1 model_reset();
        check_outputs();
        @(negedge Hclk);
        check_outputs();
        Hresetn = 1'b1;
        repeat (400) cycle(0);
        repeat (200) cycle(1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
